mac_se_video_out: RTL and testbench

- Reader side of the 512x342 1bpp frame buffer that the input scaler fills.
- Sweeps the buffer in raster order on the Mac SE pixel clock and emits the Mac SE internal CRT signals: hsync_n, vsync_n and serial video.
- Sits between the frame buffer read port (1-cycle synchronous read latency) and the Mac SE analog-board connector drivers.

---
 rtl/mac_se_video_out_if.sv | 14 +
 rtl/mac_se_video_out.sv | 201 ++++++++++++++++++++
 tb/tb_mac_se_video_out.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mac_se_video_out_if.sv
// Frame buffer read port between the raster reader (master) and the 1bpp buffer (slave).
// Read data is expected one clock after fb_rd_en with the address presented alongside it.
interface mac_se_video_out_if #(
  parameter int XW = 9,
  parameter int YW = 9
);
  logic          fb_rd_en;
  logic [XW-1:0] fb_rd_x;
  logic [YW-1:0] fb_rd_y;
  logic          fb_rd_data;

  modport master (output fb_rd_en, output fb_rd_x, output fb_rd_y, input fb_rd_data);
  modport slave  (input fb_rd_en, input fb_rd_x, input fb_rd_y, output fb_rd_data);
endinterface

// File: rtl/mac_se_video_out.sv
// Mac SE raster reader: sweeps the 512x342 frame buffer and emits hsync_n/vsync_n/video with 3-clk latency.
// Optional checkerboard source enabled by defining MAC_SE_TEST_PATTERN_EN.
module mac_se_video_out #(
  parameter int H_ACTIVE     = 512,
  parameter int H_FP         = 14,
  parameter int H_SYNC       = 128,
  parameter int H_BP         = 50,
  parameter int V_ACTIVE     = 342,
  parameter int V_FP         = 0,
  parameter int V_SYNC       = 4,
  parameter int V_BP         = 24,
  parameter int VIDEO_INVERT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               test_pattern,
  mac_se_video_out_if.master fb,
  output logic               hsync_n,
  output logic               vsync_n,
  output logic               video,
  output logic               active,
  output logic               frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int XW      = $clog2(H_ACTIVE);
  localparam int YW      = $clog2(V_ACTIVE);
  localparam logic INV   = VIDEO_INVERT[0];

  localparam logic [1:0] PH_ACTIVE = 2'd0;
  localparam logic [1:0] PH_FP     = 2'd1;
  localparam logic [1:0] PH_SYNC   = 2'd2;
  localparam logic [1:0] PH_BP     = 2'd3;

  // Range decode, so a zero-length phase simply never matches.
  function automatic logic [1:0] h_phase(input logic [HW-1:0] h);
    if (h < HW'(H_ACTIVE))                    return PH_ACTIVE;
    else if (h < HW'(H_ACTIVE + H_FP))        return PH_FP;
    else if (h < HW'(H_ACTIVE + H_FP + H_SYNC)) return PH_SYNC;
    else                                      return PH_BP;
  endfunction

  function automatic logic [1:0] v_phase(input logic [VW-1:0] v);
    if (v < VW'(V_ACTIVE))                    return PH_ACTIVE;
    else if (v < VW'(V_ACTIVE + V_FP))        return PH_FP;
    else if (v < VW'(V_ACTIVE + V_FP + V_SYNC)) return PH_SYNC;
    else                                      return PH_BP;
  endfunction

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [1:0]    h_ph, v_ph;
  logic          tp_mode, lit;

  logic          rd_en_p1_q, rd_en_p1_d;
  logic [XW-1:0] rd_x_p1_q, rd_x_p1_d;
  logic [YW-1:0] rd_y_p1_q, rd_y_p1_d;
  logic          vld_p1_q, vld_p1_d, hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d, fs_p1_q, fs_p1_d;
  logic          vld_p2_q, vld_p2_d, hs_p2_q, hs_p2_d, vs_p2_q, vs_p2_d, fs_p2_q, fs_p2_d;
  logic          video_q, video_d, active_q, active_d, hsync_n_q, hsync_n_d;
  logic          vsync_n_q, vsync_n_d, frame_start_q, frame_start_d;

  assign h_ph = h_phase(h_cnt_q);
  assign v_ph = v_phase(v_cnt_q);

`ifdef MAC_SE_TEST_PATTERN_EN
  logic tp_p1_q, tp_p1_d, tp_p2_q, tp_p2_d, pat_p1_q, pat_p1_d, pat_p2_q, pat_p2_d;

  always_comb begin
    tp_mode  = test_pattern;
    tp_p1_d  = enable & test_pattern;
    pat_p1_d = enable & (h_cnt_q[0] ^ v_cnt_q[0]);
    tp_p2_d  = enable & tp_p1_q;
    pat_p2_d = enable & pat_p1_q;
    lit      = tp_p2_q ? pat_p2_q : fb.fb_rd_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tp_p1_q  <= 1'b0;
      tp_p2_q  <= 1'b0;
      pat_p1_q <= 1'b0;
      pat_p2_q <= 1'b0;
    end else begin
      tp_p1_q  <= tp_p1_d;
      tp_p2_q  <= tp_p2_d;
      pat_p1_q <= pat_p1_d;
      pat_p2_q <= pat_p2_d;
    end
  end
`else
  logic unused_test_pattern;
  assign unused_test_pattern = test_pattern;
  assign tp_mode = 1'b0;
  assign lit     = fb.fb_rd_data;
`endif

  always_comb begin
    h_cnt_d       = '0;
    v_cnt_d       = '0;
    rd_en_p1_d    = 1'b0;
    rd_x_p1_d     = '0;
    rd_y_p1_d     = '0;
    vld_p1_d      = 1'b0;
    hs_p1_d       = 1'b1;
    vs_p1_d       = 1'b1;
    fs_p1_d       = 1'b0;
    vld_p2_d      = 1'b0;
    hs_p2_d       = 1'b1;
    vs_p2_d       = 1'b1;
    fs_p2_d       = 1'b0;
    video_d       = INV;
    active_d      = 1'b0;
    hsync_n_d     = 1'b1;
    vsync_n_d     = 1'b1;
    frame_start_d = 1'b0;
    if (enable) begin
      // Counters: line wrap advances the row.
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == HW'(H_TOTAL - 1)) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + VW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
      // S1: issue the read and start the control pipeline.
      vld_p1_d   = (h_ph == PH_ACTIVE) && (v_ph == PH_ACTIVE);
      rd_en_p1_d = vld_p1_d && !tp_mode;
      rd_x_p1_d  = rd_en_p1_d ? h_cnt_q[XW-1:0] : rd_x_p1_q;
      rd_y_p1_d  = rd_en_p1_d ? v_cnt_q[YW-1:0] : rd_y_p1_q;
      hs_p1_d    = (h_ph != PH_SYNC);
      vs_p1_d    = (v_ph != PH_SYNC);
      fs_p1_d    = (h_cnt_q == '0) && (v_cnt_q == '0);
      // S2: read data in flight.
      vld_p2_d   = vld_p1_q;
      hs_p2_d    = hs_p1_q;
      vs_p2_d    = vs_p1_q;
      fs_p2_d    = fs_p1_q;
      // S3: pixel meets its aligned sync and flags.
      video_d       = vld_p2_q ? (lit ^ INV) : INV;
      active_d      = vld_p2_q;
      hsync_n_d     = hs_p2_q;
      vsync_n_d     = vs_p2_q;
      frame_start_d = fs_p2_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      rd_en_p1_q    <= 1'b0;
      rd_x_p1_q     <= '0;
      rd_y_p1_q     <= '0;
      vld_p1_q      <= 1'b0;
      hs_p1_q       <= 1'b1;
      vs_p1_q       <= 1'b1;
      fs_p1_q       <= 1'b0;
      vld_p2_q      <= 1'b0;
      hs_p2_q       <= 1'b1;
      vs_p2_q       <= 1'b1;
      fs_p2_q       <= 1'b0;
      video_q       <= INV;
      active_q      <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      rd_en_p1_q    <= rd_en_p1_d;
      rd_x_p1_q     <= rd_x_p1_d;
      rd_y_p1_q     <= rd_y_p1_d;
      vld_p1_q      <= vld_p1_d;
      hs_p1_q       <= hs_p1_d;
      vs_p1_q       <= vs_p1_d;
      fs_p1_q       <= fs_p1_d;
      vld_p2_q      <= vld_p2_d;
      hs_p2_q       <= hs_p2_d;
      vs_p2_q       <= vs_p2_d;
      fs_p2_q       <= fs_p2_d;
      video_q       <= video_d;
      active_q      <= active_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign fb.fb_rd_en = rd_en_p1_q;
  assign fb.fb_rd_x  = rd_x_p1_q;
  assign fb.fb_rd_y  = rd_y_p1_q;
  assign video       = video_q;
  assign active      = active_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_mac_se_video_out.sv
// Directed bench for mac_se_video_out on a shrunken 16x8 raster (8x4 visible) so frames stay short.
// Frame buffer model: only (0,0) and (7,3) are lit; unread cycles return 1 to expose ungated video.
module tb_mac_se_video_out;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 0, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;  // 16
  localparam int VT = VA + VF + VS + VB;  // 8
  localparam int FRAME = HT * VT;         // 128

  logic clk = 1'b0;
  logic reset, enable, test_pattern;
  logic hsync_n, vsync_n, video, active, frame_start;
  int   checks = 0;
  int   errors = 0;

  mac_se_video_out_if #(.XW(3), .YW(2)) fb_if ();

  mac_se_video_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .VIDEO_INVERT(0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .test_pattern(test_pattern),
    .fb(fb_if), .hsync_n(hsync_n), .vsync_n(vsync_n), .video(video),
    .active(active), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    fb_if.fb_rd_data <= fb_if.fb_rd_en
                        ? ((fb_if.fb_rd_x == 3'd0 && fb_if.fb_rd_y == 2'd0) ||
                           (fb_if.fb_rd_x == 3'd7 && fb_if.fb_rd_y == 2'd3))
                        : 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {rd_en, x[2:0], y[1:0], hsync_n, vsync_n, video, active, frame_start}; idle = 0_000_00_11000
  task automatic chk_idle(input string tag);
    chk(tag, {21'd0, fb_if.fb_rd_en, fb_if.fb_rd_x, fb_if.fb_rd_y,
              hsync_n, vsync_n, video, active, frame_start}, 32'b000_0000_0011_000);
  endtask

  // Called right after the raster has been released at a negedge.
  task automatic start_check(input string tag);
    int lat;
    @(negedge clk);
    chk({tag, "_first_read"}, {28'd0, fb_if.fb_rd_en, fb_if.fb_rd_x}, 32'h8);
    chk({tag, "_first_row"}, {30'd0, fb_if.fb_rd_y}, 32'h0);
    lat = 1;
    while (frame_start !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_fs_latency"}, lat, 3);
    chk({tag, "_fs_active_video"}, {30'd0, active, video}, 32'h3);
  endtask

  initial begin
    int fs_idx[$];
    int vid_idx[$];
    int n_act, n_hs, n_vs, n_vid, n_rd, act_fall, hs_fall, vs_fall;
    logic prev_act, prev_hs, prev_vs;

    reset = 1'b1;
    enable = 1'b1;
    test_pattern = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset_idle");

    reset = 1'b0;
    start_check("boot");

    n_act = 0; n_hs = 0; n_vs = 0; n_vid = 0; n_rd = 0;
    act_fall = -1; hs_fall = -1; vs_fall = -1;
    prev_act = 1'b1; prev_hs = 1'b1; prev_vs = 1'b1;
    for (int i = 0; i <= 2 * FRAME; i++) begin
      if (frame_start) fs_idx.push_back(i);
      if (video) vid_idx.push_back(i);
      if (i < FRAME) begin
        if (active) n_act++;
        if (!hsync_n) n_hs++;
        if (!vsync_n) n_vs++;
        if (video) n_vid++;
        if (fb_if.fb_rd_en) n_rd++;
      end
      if (prev_act && !active && act_fall < 0) act_fall = i;
      if (prev_hs && !hsync_n && hs_fall < 0) hs_fall = i;
      if (prev_vs && !vsync_n && vs_fall < 0) vs_fall = i;
      prev_act = active;
      prev_hs = hsync_n;
      prev_vs = vsync_n;
      @(negedge clk);
    end
    chk("fs_count", fs_idx.size(), 3);
    if (fs_idx.size() == 3) begin
      chk("fs_period_1", fs_idx[1], FRAME);
      chk("fs_period_2", fs_idx[2], 2 * FRAME);
    end
    chk("active_per_frame", n_act, 32);
    chk("active_fall", act_fall, 8);
    chk("hsync_low_per_frame", n_hs, 24);
    chk("hsync_fall", hs_fall, 10);
    chk("vsync_low_per_frame", n_vs, 32);
    chk("vsync_fall", vs_fall, 64);
    chk("video_lit_per_frame", n_vid, 2);
    chk("video_lit_count", vid_idx.size(), 5);
    if (vid_idx.size() == 5) chk("video_last_pixel", vid_idx[1], 55);
    chk("rd_en_per_frame", n_rd, 32);

    // Now at frame position 1; move to line 1, h=5 (reads lead outputs by two pixels).
    repeat (20) @(negedge clk);
    chk("midline_state", {26'd0, fb_if.fb_rd_en, fb_if.fb_rd_x, fb_if.fb_rd_y, active, video},
        {26'd0, 1'b1, 3'd7, 2'd1, 1'b1, 1'b0});
    enable = 1'b0;
    @(negedge clk);
    chk_idle("enable_drop_idle");
    repeat (4) @(negedge clk);
    chk_idle("enable_low_hold");
    enable = 1'b1;
    start_check("reenable");

    // Line 4 is the first vsync line (no vertical front porch); h=11 is inside hsync.
    repeat (75) @(negedge clk);
    chk("sync_before_reset", {29'd0, hsync_n, vsync_n, active}, 32'h0);
    #1 reset = 1'b1;
    #1 chk_idle("async_reset_idle");
    @(negedge clk);
    reset = 1'b0;
    start_check("after_reset");

`ifdef MAC_SE_TEST_PATTERN_EN
    test_pattern = 1'b1;
    repeat (16) @(negedge clk);
    chk("tp_line1_h0", {30'd0, fb_if.fb_rd_en, video}, 32'h1);
    @(negedge clk);
    chk("tp_line1_h1", {30'd0, fb_if.fb_rd_en, video}, 32'h0);
    repeat (15) @(negedge clk);
    chk("tp_line2_h0", {30'd0, fb_if.fb_rd_en, video}, 32'h0);
    @(negedge clk);
    chk("tp_line2_h1", {30'd0, fb_if.fb_rd_en, video}, 32'h1);
    test_pattern = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
